// File: rtl/serial_addsub_seq_pkg.sv
// Shared types and constants for the bit-serial add/sub controller.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_if.sv
// Host-side start/ready/done handshake and operand/result bus.
interface serial_addsub_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  ready, done, result, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output ready, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_seq_fa_bit_slice.sv
// Single-bit combinational full adder; knows nothing about add/subtract mode.
module fa_bit_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice stepped LSB first,
// one bit per clock, behind a start/ready/done handshake.
module serial_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic             c_msb_in;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;

    fa_bit_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            r_sh         <= '0;
            carry        <= 1'b0;
            c_msb_in     <= 1'b0;
            cnt          <= '0;
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert B here and seed the carry with mode.
                        a_sh         <= bus.a;
                        b_sh         <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                        carry        <= bus.mode;
                        cnt          <= '0;
                        r_sh         <= '0;
                        bus.result   <= '0;
                        bus.cout     <= 1'b0;
                        bus.overflow <= 1'b0;
                        bus.ready    <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= {s, r_sh[WIDTH-1:1]};
                    carry <= co;
                    if (cnt == CNT_W'(WIDTH - 2)) begin
                        c_msb_in <= co;
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // Publish the whole word at once so partial bits never appear on result.
                        bus.result   <= {s, r_sh[WIDTH-1:1]};
                        bus.cout     <= co;
                        bus.overflow <= c_msb_in ^ co;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
- Bit-serial N-bit adder/subtractor controller. Sequences a single 1-bit full-adder slice over WIDTH cycles, LSB first.
- Implements two's-complement subtraction by inverting B and seeding the carry with 1.
- Sits beside the combinational bit-level add/sub cells as the area-minimal alternative to a ripple array. A host drives it through a start/ready/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE only
- done  output  1  single-cycle pulse when result/flags become valid
- result  output  WIDTH  sum/difference; held until next accepted start
- cout  output  1  final carry out; in subtract mode 1 = no borrow (a >= b unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high; it is sampled on the rising edge of clk only.
- Reset values:
  - state = IDLE, ready = 1, done = 0.
  - result = 0, cout = 0, overflow = 0.
  - Internal shift registers, carry and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready = 1.
  - On an edge with start=1:
    - Latch a into the A shift register.
    - Latch (mode ? ~b : b) into the B shift register.
    - carry <= mode.
    - cnt <= 0.
    - Clear the result shift register.
    - Go to RUN.
  - ready drops the cycle after acceptance.
- RUN:
  - ready = 0. Each edge processes bit cnt using the slice: s = a0^b0^c, co = a0&b0 | c&(a0^b0).
  - A and B shift right by one. s is shifted into the MSB of the result register. carry <= co.
  - On the edge where cnt = WIDTH-2, capture c_msb_in <= co; this is the carry into the MSB.
  - On the edge where cnt = WIDTH-1:
    - Go to DONE.
    - cout <= co.
    - overflow <= c_msb_in ^ co.
  - Otherwise cnt <= cnt+1.
- DONE:
  - done = 1 for exactly this one cycle; result, cout and overflow are already valid.
  - Next edge returns unconditionally to IDLE.
- Latency: start sampled at edge k; done is high during the cycle after edge k+WIDTH. That is WIDTH RUN cycles, then 1 DONE cycle.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is accepted again on the first IDLE edge.
- start while ready=0 (RUN or DONE): ignored. No queueing and no error flag.
- Changes on a, b or mode after acceptance: no effect.
- Outputs:
  - result, cout and overflow are held from DONE until the next acceptance.
  - At acceptance they are cleared to 0 and update only on completion.
  - Partial result bits are never visible on result.
- Counter width is $clog2(WIDTH). Wrap-around is impossible because the counter leaves RUN at WIDTH-1.
- rst asserted in any state:
  - The operation in progress is aborted on that edge, and all outputs take their reset values.
  - start on the same edge as rst is ignored.
- Arithmetic is modulo 2^WIDTH. Unsigned carry and signed overflow are reported independently.

Decomposition:
- Shared package addsub_pkg:
  - enum state_t {IDLE, RUN, DONE}.
  - Localparams MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- One natural sub-module: fa_bit_slice.
  - Pure combinational full adder: inputs a, b, ci; outputs s, co.
  - Instantiated once.
  - The controller owns the B inversion and the carry seeding; the slice never sees mode.

Test Plan (WIDTH=4):
- Add 5+3: a=0101, b=0011, mode=0, start -> done exactly 5 edges after acceptance edge; result=1000, cout=0, overflow=1.
- Subtract 7-2: a=0111, b=0010, mode=1 -> result=0101, cout=1, overflow=0.
- Subtract 2-7 -> result=1011, cout=0 (borrow), overflow=0. Subtract 8-1 (1000-0001) -> result=0111, overflow=1.
- Add F+1 -> result=0000, cout=1, overflow=0. Then hold start=1 continuously -> back-to-back acceptances every 6 cycles; done pulses exactly one cycle each.
- Pulse start with different operands 2 cycles into RUN -> ignored; result matches the first operation. Changes on a/b during RUN -> no effect.
- Assert rst at cnt=2 of an operation -> next cycle state=IDLE, ready=1, done=0, result/cout/overflow=0. A new start afterwards completes correctly.
